// File: rtl/eu_pkg.sv
// Shared definitions for the execution-unit controller: opcodes, instruction
// field positions and the sequencer state type.
package eu_pkg;

  localparam int unsigned INSTR_W = 16;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'hE;
  localparam logic [3:0] OP_STORE = 4'hF;

  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 12;
  localparam int unsigned DEST_MSB   = 11;
  localparam int unsigned DEST_LSB   = 9;
  localparam int unsigned SRCA_MSB   = 8;
  localparam int unsigned SRCA_LSB   = 6;
  localparam int unsigned SRCB_MSB   = 5;
  localparam int unsigned SRCB_LSB   = 3;
  // Memory address overlaps srcB's low bit; only LOAD/STORE interpret it.
  localparam int unsigned MADDR_MSB  = 3;
  localparam int unsigned MADDR_LSB  = 0;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StMemWait,
    StWriteback,
    StHalt
  } ctrl_state_t;

endpackage

// File: rtl/eu_instr_decoder.sv
// Purely combinational split of the instruction register into eu fields and
// instruction-class flags.
module eu_instr_decoder
  import eu_pkg::*;
(
  input  logic [INSTR_W-1:0] ir_i,
  output logic [3:0]         opcode_o,
  output logic [2:0]         dest_reg_o,
  output logic [2:0]         src_a_o,
  output logic [2:0]         src_b_o,
  output logic [3:0]         mem_addr_o,
  output logic               is_load_o,
  output logic               is_store_o,
  output logic               is_halt_o
);

  always_comb begin
    opcode_o   = ir_i[OPCODE_MSB:OPCODE_LSB];
    dest_reg_o = ir_i[DEST_MSB:DEST_LSB];
    src_a_o    = ir_i[SRCA_MSB:SRCA_LSB];
    src_b_o    = ir_i[SRCB_MSB:SRCB_LSB];
    mem_addr_o = ir_i[MADDR_MSB:MADDR_LSB];
    is_load_o  = (opcode_o == OP_LOAD);
    is_store_o = (opcode_o == OP_STORE);
    is_halt_o  = (opcode_o == OP_HALT);
  end

endmodule

// File: rtl/eu_controller.sv
// Multi-cycle fetch/decode/execute sequencer between the instruction ROM and the eu;
// gates eu write requests so each instruction commits at most once.
module eu_controller
  import eu_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [3:0]             eu_opcode,
  output logic [2:0]             eu_dest_reg,
  output logic [2:0]             eu_opAAdr,
  output logic [2:0]             eu_opBAdr,
  output logic [3:0]             eu_storeDataAdr,
  output logic                   eu_issue,
  input  logic                   eu_write_enable,
  input  logic                   eu_dmem_write_enable,
  output logic                   rf_write_enable,
  output logic                   dmem_write_enable,
  input  logic                   dmem_ready,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   busy,
  output logic                   halted,
  output logic [CNT_WIDTH-1:0]   instr_count
);

  ctrl_state_t            state;
  logic [INSTR_WIDTH-1:0] ir;
  logic                   is_load;
  logic                   is_store;
  logic                   is_halt;
  logic                   fetched_halt;

  eu_instr_decoder u_decoder (
    .ir_i       (ir),
    .opcode_o   (eu_opcode),
    .dest_reg_o (eu_dest_reg),
    .src_a_o    (eu_opAAdr),
    .src_b_o    (eu_opBAdr),
    .mem_addr_o (eu_storeDataAdr),
    .is_load_o  (is_load),
    .is_store_o (is_store),
    .is_halt_o  (is_halt)
  );

  assign imem_addr    = pc;
  assign fetched_halt = (imem_data[OPCODE_MSB:OPCODE_LSB] == OP_HALT);

  // The only input-to-output paths: eu requests pass through only in their windows.
  assign rf_write_enable   = (state == StWriteback) & ~is_halt & eu_write_enable;
  assign dmem_write_enable = (state == StMemWait) & is_store & eu_dmem_write_enable;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= StIdle;
      pc          <= '0;
      instr_count <= '0;
      ir          <= '0;
      eu_issue    <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      eu_issue <= 1'b0;
      case (state)
        StIdle, StHalt: begin
          if (start) begin
            pc     <= '0;
            state  <= StFetch;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        StFetch: state <= StDecode;
        StDecode: begin
          ir <= imem_data;
          if (fetched_halt) begin
            state  <= StHalt;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state    <= StExecute;
            eu_issue <= 1'b1;
          end
        end
        StExecute: state <= (is_load || is_store) ? StMemWait : StWriteback;
        StMemWait: begin
          if (dmem_ready) begin
            if (is_store) begin
              pc    <= pc + PC_WIDTH'(1);
              state <= StFetch;
              if (instr_count != '1) instr_count <= instr_count + CNT_WIDTH'(1);
            end else begin
              state <= StWriteback;
            end
          end
        end
        StWriteback: begin
          pc    <= pc + PC_WIDTH'(1);
          state <= StFetch;
          if (instr_count != '1) instr_count <= instr_count + CNT_WIDTH'(1);
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eu_controller.sv
// Directed bench for eu_controller: ALU/LOAD/STORE/HALT flows, reset mid-store,
// and pc wrap with counter saturation on a narrow second instance.
module tb_eu_controller;

  logic        clk = 1'b0;
  logic        reset, start, start2;
  logic        eu_write_enable, eu_dmem_write_enable, dmem_ready;
  logic [7:0]  imem_addr, pc;
  logic [15:0] imem_data, instr_count;
  logic [3:0]  eu_opcode, eu_storeDataAdr;
  logic [2:0]  eu_dest_reg, eu_opAAdr, eu_opBAdr;
  logic        eu_issue, rf_write_enable, dmem_write_enable, busy, halted;

  logic [1:0]  imem_addr2, pc2, instr_count2;
  logic [15:0] imem_data2;
  logic [3:0]  eu_opcode2, eu_storeDataAdr2;
  logic [2:0]  eu_dest_reg2, eu_opAAdr2, eu_opBAdr2;
  logic        eu_issue2, rf_write_enable2, dmem_write_enable2, busy2, halted2;

  logic [15:0] rom [256];
  logic [15:0] rom2 [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_data  <= rom[imem_addr];
  always @(posedge clk) imem_data2 <= rom2[imem_addr2];

  eu_controller dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .imem_addr            (imem_addr),
    .imem_data            (imem_data),
    .eu_opcode            (eu_opcode),
    .eu_dest_reg          (eu_dest_reg),
    .eu_opAAdr            (eu_opAAdr),
    .eu_opBAdr            (eu_opBAdr),
    .eu_storeDataAdr      (eu_storeDataAdr),
    .eu_issue             (eu_issue),
    .eu_write_enable      (eu_write_enable),
    .eu_dmem_write_enable (eu_dmem_write_enable),
    .rf_write_enable      (rf_write_enable),
    .dmem_write_enable    (dmem_write_enable),
    .dmem_ready           (dmem_ready),
    .pc                   (pc),
    .busy                 (busy),
    .halted               (halted),
    .instr_count          (instr_count)
  );

  eu_controller #(.PC_WIDTH(2), .INSTR_WIDTH(16), .CNT_WIDTH(2)) dut2 (
    .clk                  (clk),
    .reset                (reset),
    .start                (start2),
    .imem_addr            (imem_addr2),
    .imem_data            (imem_data2),
    .eu_opcode            (eu_opcode2),
    .eu_dest_reg          (eu_dest_reg2),
    .eu_opAAdr            (eu_opAAdr2),
    .eu_opBAdr            (eu_opBAdr2),
    .eu_storeDataAdr      (eu_storeDataAdr2),
    .eu_issue             (eu_issue2),
    .eu_write_enable      (1'b1),
    .eu_dmem_write_enable (1'b0),
    .rf_write_enable      (rf_write_enable2),
    .dmem_write_enable    (dmem_write_enable2),
    .dmem_ready           (1'b0),
    .pc                   (pc2),
    .busy                 (busy2),
    .halted               (halted2),
    .instr_count          (instr_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", halted, 1);
  endtask

  task automatic launch();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 4; i++) rom2[i] = 16'h1448;
    reset = 1'b0; start = 1'b0; start2 = 1'b0; dmem_ready = 1'b0;
    eu_write_enable = 1'b1; eu_dmem_write_enable = 1'b1;
    step(2);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc, 0);
    check("rst_count", instr_count, 0);
    check("rst_issue", eu_issue, 0);
    check("rst_rf_we", rf_write_enable, 0);
    check("rst_opcode", eu_opcode, 0);
    reset = 1'b1;
    step(1);

    // ALU op: issue in cycle 3, writeback in cycle 4
    rom[0] = 16'h1448;
    launch();
    check("alu_busy", busy, 1);
    check("alu_c1_pc", pc, 0);
    step(1);
    check("alu_c2_issue", eu_issue, 0);
    step(1);
    check("alu_c3_issue", eu_issue, 1);
    check("alu_opcode", eu_opcode, 4'h1);
    check("alu_dest", eu_dest_reg, 3'd2);
    check("alu_srca", eu_opAAdr, 3'd1);
    check("alu_srcb", eu_opBAdr, 3'd1);
    check("alu_c3_rf_we", rf_write_enable, 0);
    step(1);
    check("alu_c4_rf_we", rf_write_enable, 1);
    check("alu_c4_issue", eu_issue, 0);
    check("alu_c4_dmem_we", dmem_write_enable, 0);
    step(1);
    check("alu_c5_rf_we", rf_write_enable, 0);
    check("alu_pc", pc, 1);
    check("alu_count", instr_count, 1);
    wait_halt(10);
    check("alu_halt_pc", pc, 1);

    // LOAD with two wait cycles
    rom[0] = 16'hE605;
    launch();
    check("ld_unhalt", halted, 0);
    step(2);
    check("ld_issue", eu_issue, 1);
    check("ld_opcode", eu_opcode, 4'hE);
    check("ld_addr", eu_storeDataAdr, 4'h5);
    check("ld_dest", eu_dest_reg, 3'd3);
    step(1);
    check("ld_w1_rf_we", rf_write_enable, 0);
    check("ld_w1_dmem_we", dmem_write_enable, 0);
    check("ld_w1_busy", busy, 1);
    step(1);
    check("ld_w2_rf_we", rf_write_enable, 0);
    check("ld_w2_dmem_we", dmem_write_enable, 0);
    dmem_ready = 1'b1;
    step(1);
    dmem_ready = 1'b0;
    check("ld_wb_rf_we", rf_write_enable, 1);
    check("ld_wb_dmem_we", dmem_write_enable, 0);
    step(1);
    check("ld_post_rf_we", rf_write_enable, 0);
    check("ld_pc", pc, 1);
    check("ld_count", instr_count, 2);
    wait_halt(10);

    // STORE: strobe only while waiting on memory
    rom[0] = 16'hF04A;
    launch();
    step(2);
    check("st_issue", eu_issue, 1);
    check("st_opcode", eu_opcode, 4'hF);
    check("st_data_reg", eu_opAAdr, 3'd1);
    check("st_addr", eu_storeDataAdr, 4'hA);
    check("st_ex_dmem_we", dmem_write_enable, 0);
    step(1);
    check("st_mw_dmem_we", dmem_write_enable, 1);
    check("st_mw_rf_we", rf_write_enable, 0);
    dmem_ready = 1'b1;
    step(1);
    dmem_ready = 1'b0;
    check("st_post_dmem_we", dmem_write_enable, 0);
    check("st_post_rf_we", rf_write_enable, 0);
    check("st_pc", pc, 1);
    check("st_count", instr_count, 3);
    wait_halt(10);

    // HALT after two ALU ops, then restart from pc 0
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    rom[0] = 16'h1448; rom[1] = 16'h1448; rom[2] = 16'h0000;
    launch();
    wait_halt(30);
    check("hlt_pc", pc, 2);
    check("hlt_count", instr_count, 2);
    check("hlt_busy", busy, 0);
    launch();
    check("hlt_restart_pc", pc, 0);
    check("hlt_restart_busy", busy, 1);
    check("hlt_restart_halted", halted, 0);
    check("hlt_restart_count", instr_count, 2);
    wait_halt(30);

    // Reset during the memory wait of a STORE
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    rom[0] = 16'hF04A;
    launch();
    step(3);
    check("rs_mw_dmem_we", dmem_write_enable, 1);
    reset = 1'b0;
    step(1);
    check("rs_busy", busy, 0);
    check("rs_halted", halted, 0);
    check("rs_pc", pc, 0);
    check("rs_count", instr_count, 0);
    check("rs_dmem_we", dmem_write_enable, 0);
    check("rs_opcode", eu_opcode, 0);
    check("rs_addr", eu_storeDataAdr, 0);
    reset = 1'b1;
    dmem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("rs_after_dmem_we", dmem_write_enable, 0);
      check("rs_after_busy", busy, 0);
    end
    dmem_ready = 1'b0;

    // Narrow instance: pc wraps 3 -> 0, counter saturates at 3, busy start ignored
    start2 = 1'b1;
    step(1);
    start2 = 1'b0;
    check("wr_pc0", pc2, 0);
    for (int k = 1; k <= 4; k++) begin
      step(2);
      start2 = 1'b1;
      step(1);
      start2 = 1'b0;
      step(1);
      check("wr_pc", pc2, k % 4);
      check("wr_count", instr_count2, (k > 3) ? 3 : k);
      check("wr_busy", busy2, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
